// File: rtl/latch_bank_writer.sv
// latch_bank_writer: write-side sequencer for a bank of transparent latches.
// Each accepted write runs SETUP -> ENABLE -> HOLD so that the shared data bus
// is stable around the whole enable window of the addressed latch word.
module latch_bank_writer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  output logic [DATA_W-1:0]      lat_d,
  output logic [(1<<ADDR_W)-1:0] lat_en,
  output logic                   busy,
  output logic                   done
);

  localparam int NWORDS  = 1 << ADDR_W;
  localparam int MAX_SE  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAX_CYC = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ENABLE,
    ST_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   lat_d_q, lat_d_d;
  logic [NWORDS-1:0]   lat_en_q, lat_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  assign in_ready = (state_q == ST_IDLE);
  assign lat_d    = lat_d_q;
  assign lat_en   = lat_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Next-state, phase counter and registered output values.
  // Enables and busy are derived from the next state so they are flopped
  // alongside it and can only change at clock edges.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    lat_d_d  = lat_d_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          addr_d  = in_addr;
          lat_d_d = in_data;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ENABLE;
          cnt_d   = EN_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ENABLE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    lat_en_d = '0;
    if (state_d == ST_ENABLE) begin
      lat_en_d[addr_d] = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears the bus and enables immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_latch_bank_writer.sv
// Bench for latch_bank_writer: default-parameter instance checked through a
// write scoreboard, plus a second instance with SETUP=3, EN=1, HOLD=2.
module tb_latch_bank_writer;

  localparam int S = 1;
  localparam int E = 2;
  localparam int H = 1;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, busy, done;
  logic [1:0] in_addr;
  logic [7:0] in_data, lat_d;
  logic [3:0] lat_en;

  logic       v2, rdy2, busy2, done2;
  logic [1:0] a2;
  logic [7:0] d2, ld2;
  logic [3:0] en2;

  latch_bank_writer u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .lat_d(lat_d), .lat_en(lat_en),
    .busy(busy), .done(done)
  );

  latch_bank_writer #(.DATA_W(8), .ADDR_W(2), .SETUP_CYC(3), .EN_CYC(1), .HOLD_CYC(2)) u_sweep (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
    .in_addr(a2), .in_data(d2), .lat_d(ld2), .lat_en(en2),
    .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    int         acc;
    bit         b2b;
  } item_t;

  item_t sb[$];

  int         en_start = 0;
  int         en_len = 0;
  bit         en_active = 0;
  logic [3:0] en_val = '0;
  logic [7:0] en_dat = '0;
  int         last_done = -100;
  logic [7:0] prev_ld = '0;
  logic       prev_busy = 1'b0;

  // Monitor: measures each enable pulse and retires one scoreboard entry per done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_busy && lat_d !== prev_ld) check("lat_d_stable", lat_d, prev_ld);
      if (lat_en != 4'b0000) begin
        check("onehot", $countones(lat_en), 1);
        if (!en_active) begin
          en_active = 1;
          en_start  = cyc;
          en_val    = lat_en;
          en_dat    = lat_d;
        end
      end else if (en_active) begin
        en_active = 0;
        en_len    = cyc - en_start;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          item_t it;
          it = sb.pop_front();
          check("en_start", en_start - it.acc, S);
          check("en_len", en_len, E);
          check("en_addr", en_val, 4'b0001 << it.addr);
          check("en_data", en_dat, it.data);
          check("done_time", cyc - it.acc, S + E + H);
          check("done_lat_d", lat_d, it.data);
          check("done_busy", busy, 0);
          check("done_ready", in_ready, 1);
          if (it.b2b) check("b2b_accept", it.acc, last_done + 1);
          last_done = cyc;
        end
      end
    end
    prev_ld   = lat_d;
    prev_busy = busy;
  end

  // Present a write, wait (bounded) for ready and log the expected result.
  task automatic do_write(input logic [1:0] a, input logic [7:0] d, input bit drop, input bit b2b);
    int n = 0;
    in_addr  = a;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", in_ready, 1);
    sb.push_back('{a, d, cyc + 1, b2b});
    @(negedge clk);
    if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_en(input logic [3:0] val);
    int n = 0;
    while (lat_en !== val && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_en", lat_en, val);
  endtask

  task automatic sweep_test();
    int n = 0;
    int busy_n = 0;
    int en_n = 0;
    int done_at = -1;
    logic [3:0] en_seen = '0;
    a2 = 2'd3;
    d2 = 8'h5A;
    v2 = 1'b1;
    while (!rdy2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sw_ready", rdy2, 1);
    @(negedge clk);
    v2 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (busy2) busy_n++;
      if (en2 != 4'b0000) begin
        en_n++;
        en_seen = en2;
      end
      if (done2 && done_at < 0) done_at = k;
      @(negedge clk);
    end
    check("sw_busy_cycles", busy_n, 6);
    check("sw_en_cycles", en_n, 1);
    check("sw_en_value", en_seen, 4'b1000);
    check("sw_done_at", done_at, 7);
    check("sw_lat_d", ld2, 8'h5A);
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 2'd1;
    in_data  = 8'hFF;
    v2 = 1'b0; a2 = '0; d2 = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_lat_d", lat_d, 8'h00);
    check("rst_lat_en", lat_en, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_ready, 1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_lat_d", lat_d, 8'h00);

    // single write
    do_write(2'd2, 8'hA5, 1, 0);
    check("setup_lat_d", lat_d, 8'hA5);
    check("setup_lat_en", lat_en, 4'b0000);
    repeat (6) @(negedge clk);

    // back-to-back with in_valid held
    do_write(2'd0, 8'h11, 0, 0);
    do_write(2'd3, 8'h22, 1, 1);
    repeat (8) @(negedge clk);

    // request during ENABLE must be ignored
    do_write(2'd2, 8'hC3, 1, 0);
    wait_en(4'b0100);
    in_addr  = 2'd1;
    in_data  = 8'h33;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("stall_lat_d", lat_d, 8'hC3);
    check("stall_sb_empty", sb.size(), 0);

    // asynchronous reset in the middle of ENABLE
    do_write(2'd1, 8'h77, 1, 0);
    wait_en(4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_lat_en", lat_en, 4'b0000);
    check("mid_rst_lat_d", lat_d, 8'h00);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    sb.delete();
    en_active = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_lat_d", lat_d, 8'h00);

    // recovery write
    do_write(2'd1, 8'h9C, 1, 0);
    repeat (8) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    check("final_lat_d", lat_d, 8'h9C);

    sweep_test();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
